// File: rtl/einstein_keyboard.sv
// rtl/einstein_keyboard.sv - PS/2 set-2 key events to Einstein 8x8 keyboard matrix and modifier lines
// Three-stage pipeline: detect toggle, translate scancode, apply to matrix; outputs registered.
module einstein_keyboard (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  kb_row,
  output logic [7:0]  kb_col,
  output logic        kb_shift,
  output logic        kb_ctrl,
  output logic        kb_graph
);

  typedef enum logic [2:0] {
    K_NONE   = 3'd0,
    K_MATRIX = 3'd1,
    K_SHIFT  = 3'd2,
    K_CTRL   = 3'd3,
    K_GRAPH  = 3'd4,
    K_CLEAR  = 3'd5
  } kind_t;

  // Free-running history: it also loads during reset, so release never sees a stale toggle.
  logic toggle_q;
  always_ff @(posedge clk_sys) begin
    toggle_q <= ps2_key[10];
  end

  logic       s1_valid;
  logic       s1_make;
  logic       s1_ext;
  logic [7:0] s1_code;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_make  <= 1'b0;
      s1_ext   <= 1'b0;
      s1_code  <= 8'h00;
    end else begin
      s1_valid <= (ps2_key[10] != toggle_q);
      s1_make  <= ps2_key[9];
      s1_ext   <= ps2_key[8];
      s1_code  <= ps2_key[7:0];
    end
  end

  kind_t      t_kind;
  logic [2:0] t_row;
  logic [2:0] t_col;

  always_comb begin
    t_kind = K_NONE;
    t_row  = 3'd0;
    t_col  = 3'd0;
    case ({s1_ext, s1_code})
      9'h029: begin t_kind = K_MATRIX; t_row = 3'd0; t_col = 3'd0; end
      9'h01C: begin t_kind = K_MATRIX; t_row = 3'd3; t_col = 3'd1; end
      9'h05A: begin t_kind = K_MATRIX; t_row = 3'd1; t_col = 3'd7; end
      9'h012, 9'h059: t_kind = K_SHIFT;
      9'h014, 9'h114: t_kind = K_CTRL;
      9'h111: t_kind = K_GRAPH;
      9'h007: t_kind = K_CLEAR;
      default: t_kind = K_NONE;
    endcase
  end

  logic       s2_valid;
  logic       s2_make;
  kind_t      s2_kind;
  logic [2:0] s2_row;
  logic [2:0] s2_col;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_make  <= 1'b0;
      s2_kind  <= K_NONE;
      s2_row   <= 3'd0;
      s2_col   <= 3'd0;
    end else begin
      s2_valid <= s1_valid;
      s2_make  <= s1_make;
      s2_kind  <= t_kind;
      s2_row   <= t_row;
      s2_col   <= t_col;
    end
  end

  logic [7:0][7:0] matrix;
  logic            mod_shift;
  logic            mod_ctrl;
  logic            mod_graph;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      matrix    <= '0;
      mod_shift <= 1'b0;
      mod_ctrl  <= 1'b0;
      mod_graph <= 1'b0;
    end else if (s2_valid) begin
      case (s2_kind)
        K_MATRIX: matrix[s2_row][s2_col] <= s2_make;
        K_SHIFT:  mod_shift <= s2_make;
        K_CTRL:   mod_ctrl  <= s2_make;
        K_GRAPH:  mod_graph <= s2_make;
        K_CLEAR: begin
          // Panic key: only the press clears; its release is a no-op.
          if (s2_make) begin
            matrix    <= '0;
            mod_shift <= 1'b0;
            mod_ctrl  <= 1'b0;
            mod_graph <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  logic [7:0] col_next;

  always_comb begin
    col_next = 8'hFF;
    for (int r = 0; r < 8; r++) begin
      if (!kb_row[r]) begin
        col_next = col_next & ~matrix[r];
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      kb_col   <= 8'hFF;
      kb_shift <= 1'b1;
      kb_ctrl  <= 1'b1;
      kb_graph <= 1'b1;
    end else begin
      kb_col   <= col_next;
      kb_shift <= ~mod_shift;
      kb_ctrl  <= ~mod_ctrl;
      kb_graph <= ~mod_graph;
    end
  end

endmodule
